// File: rtl/axi_line_fill.sv
// axi_line_fill: AXI4 read-burst master that fetches one cache line on a miss.
// Accepts a line-fill address, issues a single INCR burst of BEATS beats,
// assembles the beats into a line-wide buffer and reports completion with a
// one-cycle fill_done pulse (fill_err qualified by fill_done).
// Optional build macro: RLAST_CHECK_EN -- when defined, an rlast value that
// disagrees with the beat count on any accepted beat flags a fill error.
module axi_line_fill #(
    parameter int ADDR_SIZE  = 32,
    parameter int BLOCK_SIZE = 6,
    parameter int DATA_WIDTH = 32,
    localparam int LINE_BITS = 8 << BLOCK_SIZE,
    localparam int BEATS     = LINE_BITS / DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // cache controller / tag array side
    input  logic                  fill_req,
    input  logic [ADDR_SIZE-1:0]  fill_addr,
    output logic                  fill_ready,
    output logic                  fill_done,
    output logic                  fill_err,
    output logic [LINE_BITS-1:0]  fill_data,
    // AXI4 read address channel
    output logic [ADDR_SIZE-1:0]  m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    // AXI4 read data channel
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int CNT_W = $clog2(BEATS) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] beat_cnt;
    logic             err_sticky;
    logic             accept;
    logic             beat_take;
    logic             last_beat;
    logic             beat_bad;

    // Fixed burst shape: one INCR burst covering exactly one line.
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;

    // Handshake outputs decode straight from the state register.
    assign fill_ready    = (state == S_IDLE);
    assign m_axi_arvalid = (state == S_ADDR);
    assign m_axi_rready  = (state == S_DATA);
    assign fill_done     = (state == S_DONE);
    assign fill_err      = (state == S_DONE) & err_sticky;

    assign accept    = fill_req & fill_ready;
    assign beat_take = m_axi_rvalid & m_axi_rready;
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

`ifdef RLAST_CHECK_EN
    // A beat is bad on an error response or when rlast disagrees with the count.
    assign beat_bad = m_axi_rresp[1] | (m_axi_rlast != last_beat);

    logic unused_bits;
    assign unused_bits = ^{fill_addr[BLOCK_SIZE-1:0], m_axi_rresp[0]};
`else
    // Only SLVERR/DECERR responses mark a beat bad; rlast plays no part.
    assign beat_bad = m_axi_rresp[1];

    logic unused_bits;
    assign unused_bits = ^{fill_addr[BLOCK_SIZE-1:0], m_axi_rresp[0], m_axi_rlast};
`endif

    // Next-state decode for the IDLE -> ADDR -> DATA -> DONE -> IDLE sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept)                  state_next = S_ADDR;
            S_ADDR:  if (m_axi_arready)           state_next = S_DATA;
            S_DATA:  if (beat_take && last_beat)  state_next = S_DONE;
            S_DONE:                               state_next = S_IDLE;
            default:                              state_next = S_IDLE;
        endcase
    end

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the line-aligned burst address when a fill is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi_araddr <= '0;
        end else if (accept) begin
            m_axi_araddr <= {fill_addr[ADDR_SIZE-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
        end
    end

    // Beat counter: cleared on accept, advanced on each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= '0;
        end else if (beat_take) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    // Sticky error: cleared on accept, set by any bad beat in the burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (accept) begin
            err_sticky <= 1'b0;
        end else if (beat_take && beat_bad) begin
            err_sticky <= 1'b1;
        end
    end

    // Line buffer: each accepted beat lands in the slot selected by the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_data <= '0;
        end else if (beat_take) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (beat_cnt == CNT_W'(k)) begin
                    fill_data[k*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
                end
            end
        end
    end

endmodule
